// File: rtl/ecg_bit_packer_if.sv
// Chunk-in / word-out stream bundle between the BP entropy encoder, the bit packer
// and the substream multiplexer.
interface ecg_bit_packer_if #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned ECG_W = 50
);
    logic             in_valid;
    logic             in_ready;
    logic [ECG_W-1:0] ecg_bits;
    logic [6:0]       ecg_size;
    logic [3:0]       sign_bits;
    logic [2:0]       sign_size;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_word;
    logic             out_last;
    logic             flush_done;
    logic [7:0]       fill_level;
    logic             err_size;

    modport master (
        output in_valid, ecg_bits, ecg_size, sign_bits, sign_size, flush, out_ready,
        input  in_ready, out_valid, out_word, out_last, flush_done, fill_level, err_size
    );

    modport slave (
        input  in_valid, ecg_bits, ecg_size, sign_bits, sign_size, flush, out_ready,
        output in_ready, out_valid, out_word, out_last, flush_done, fill_level, err_size
    );
endinterface

// File: rtl/ecg_bit_packer.sv
// Concatenates variable-length ECG codewords and sign fragments into an MSB-first
// bitstream of fixed OUT_W-bit words, with end-of-slice flush and zero padding.
module ecg_bit_packer #(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned ECG_W = 50,
    parameter int unsigned ACC_W = 128
) (
    input logic             clk,
    input logic             rst,
    ecg_bit_packer_if.slave bus
);
    localparam int unsigned CH_W = ECG_W + 4;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next, acc_pop;
    logic [7:0]       fill, fill_next, fill_pop;
    logic [7:0]       shamt;
    logic             live;
    logic             err, err_next;
    logic [ECG_W-1:0] ecg_mask;
    logic [3:0]       sign_mask;
    logic [CH_W-1:0]  chunk;
    logic [6:0]       chunk_len;
    logic             size_ok;
    logic             accept;
    logic             pop;

    // live holds in_ready low until the first clock after reset releases
    assign bus.in_ready   = live && !rst && (state == RUN) && ((32'(fill) + CH_W) <= ACC_W);
    assign bus.out_valid  = (fill >= 8'(OUT_W)) || ((state == DRAIN) && (fill != '0));
    assign bus.out_last   = (state == DRAIN) && (fill != '0) && (fill <= 8'(OUT_W));
    assign bus.out_word   = acc[ACC_W-1 -: OUT_W];
    assign bus.flush_done = (state == DONE);
    assign bus.fill_level = fill;
    assign bus.err_size   = err;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    assign size_ok   = (bus.ecg_size <= 7'(ECG_W)) && (bus.sign_size <= 3'd4);
    assign chunk_len = bus.ecg_size + {4'b0000, bus.sign_size};
    // A full-width size wraps the shifted one to zero, so the mask becomes all ones
    assign ecg_mask  = (ECG_W'(1) << bus.ecg_size) - ECG_W'(1);
    assign sign_mask = (4'd1 << bus.sign_size) - 4'd1;
    assign chunk     = ({4'b0000, bus.ecg_bits & ecg_mask} << bus.sign_size)
                     | CH_W'(bus.sign_bits & sign_mask);

    // Pop is applied before append, so a same-edge chunk lands at the post-pop tail
    always_comb begin
        acc_pop  = acc;
        fill_pop = fill;
        if (pop) begin
            acc_pop  = acc << OUT_W;
            fill_pop = (fill >= 8'(OUT_W)) ? fill - 8'(OUT_W) : '0;
        end
        acc_next  = acc_pop;
        fill_next = fill_pop;
        err_next  = 1'b0;
        shamt     = '0;
        if (accept) begin
            if (!size_ok) begin
                err_next = 1'b1;
            end else if (chunk_len != '0) begin
                shamt     = 8'(ACC_W) - fill_pop - 8'(chunk_len);
                acc_next  = acc_pop | (ACC_W'(chunk) << shamt);
                fill_next = fill_pop + 8'(chunk_len);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (bus.flush) state_next = DRAIN;
            DRAIN:   if ((fill == '0) || (pop && (fill <= 8'(OUT_W)))) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            acc   <= '0;
            fill  <= '0;
            err   <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            fill  <= fill_next;
            err   <= err_next;
            live  <= 1'b1;
        end
    end

    fill_bound: assert property (@(posedge clk) disable iff (rst) (32'(fill) <= ACC_W));
endmodule

// File: doc/ecg_bit_packer.md
Name: ecg_bit_packer

Overview:
- Sits directly downstream of the BP-mode entropy encoder.
- Consumes its variable-length ECG codewords (up to 50 bits) and sign-bit fragments (up to 4 bits) and concatenates them into a contiguous MSB-first bitstream.
- Emits fixed 32-bit words on a valid/ready interface toward the substream multiplexer/rate buffer.
- Provides backpressure and an end-of-slice flush that zero-pads the final word.

Parameters:
- OUT_W, 32, output word width in bits.
- ECG_W, 50, maximum ECG codeword width; must match the encoder.
- ACC_W, 128, accumulator depth in bits; must be ≥ OUT_W + ECG_W + 4 + OUT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  chunk present; driven from the encoder's valid_op.
- in_ready  out  1  packer can accept a chunk this cycle.
- ecg_bits  in  ECG_W  codeword, right-justified; bit ecg_size-1 is sent first.
- ecg_size  in  7  number of valid ECG bits, 0..50.
- sign_bits  in  4  sign bits, right-justified; appended after the ECG bits, MSB first.
- sign_size  in  3  number of valid sign bits, 0..4.
- flush  in  1  one-cycle request to drain and pad at end of slice.
- out_valid  out  1  out_word holds a valid word.
- out_ready  in  1  downstream accepts out_word.
- out_word  out  OUT_W  packed bits; first-arrived bit is at bit OUT_W-1.
- out_last  out  1  qualifies the final word of a flush.
- flush_done  out  1  one-cycle pulse when the drain is complete.
- fill_level  out  8  number of bits currently held in the accumulator.
- err_size  out  1  one-cycle pulse on an illegal size.

Behaviour:
- Reset values: acc=0, fill_level=0, state=RUN, out_valid=0, out_last=0, flush_done=0, err_size=0. in_ready=1 one cycle after rst deasserts; in_ready=0 while rst is high.
- Accumulator:
  - MSB-aligned; valid bits occupy acc[ACC_W-1 : ACC_W-fill].
  - out_word is acc[ACC_W-1 : ACC_W-OUT_W], read combinationally from the register.
- in_ready = (state==RUN) && (fill_level + ECG_W + 4 ≤ ACC_W). This is a worst-case reservation, independent of the actual chunk size.
- Accept: in_valid && in_ready at edge N.
  - Chunk length L = ecg_size + sign_size (0..54).
  - Chunk bits = {ecg_bits[ecg_size-1:0], sign_bits[sign_size-1:0]}.
- Pop: out_valid && out_ready at edge N.
- Same-edge pop and accept: pop is applied first (shift left by OUT_W, fill -= OUT_W), then the chunk is appended at the new tail. fill_next = fill − OUT_W·pop + L.
- Output valid rule:
  - out_valid = (fill ≥ OUT_W) || (state==DRAIN && fill > 0), computed from registered state.
  - Latency from an accepting edge to out_valid is one cycle.
- L = 0 (both sizes zero): accepted, no change.
- Illegal size (ecg_size > 50 or sign_size > 4) on an accepted chunk: chunk is discarded, err_size pulses the next cycle, fill is unchanged.
- FSM:
  - RUN: flush=1 → DRAIN. A chunk accepted on the same edge as flush is included in the drain.
  - DRAIN:
    - in_ready=0.
    - Words pop as above. When fill < OUT_W, the emitted word is zero-padded in its LSBs.
    - out_last=1 on the word whose pop leaves fill=0.
    - On that pop → DONE.
    - Entering DRAIN with fill=0 → DONE with no word emitted and no out_last.
  - DONE: flush_done=1 for one cycle → RUN. Accumulator is 0.
- flush asserted outside RUN is ignored.
- rst mid-operation: the accumulator is discarded, no padding word is emitted, and all outputs return to their reset values on that edge.
- out_word and out_last are held stable while out_valid && !out_ready. No word is ever dropped or duplicated.
- fill_level never exceeds ACC_W. An assertion fires if it does.

Test Plan:
- Reset: hold rst=1 for 3 cycles → out_valid=0, fill_level=0, in_ready=0; one cycle after release in_ready=1.
- Packing: chunk ecg_bits=20'hABCDE / ecg_size=20, sign_bits=4'b1010 / sign_size=4, followed by ecg_bits=8'hFF / ecg_size=8, sign_size=0; out_ready=1 → out_word=32'hABCDEAFF, out_valid one cycle after the 2nd accept, fill_level returns to 0.
- Backpressure: out_ready=0, two chunks of 50+4 bits (all ones) → fill_level=108, in_ready=0 on the third. Then release out_ready → three words 32'hFFFFFFFF pop, fill_level=12, in_ready reasserts, order preserved.
- Flush: fill_level=12 with bits 12'hFFF, then flush=1 → single word 32'hFFF00000 with out_last=1, flush_done pulses next cycle, in_ready is 0 throughout DRAIN.
- Simultaneous: fill_level=40, out_ready=1, accept a 30-bit chunk on the same edge → fill_level=38; the popped word equals the first 32 of the original 40 bits.
- Errors and reset: ecg_size=51 → err_size pulses, fill_level unchanged. Then assert rst during DRAIN → no out_last and no flush_done, everything returns to reset state.
